horner_poly_eval: RTL and testbench

Parametrised successor to the fixed 5th-order exp(x) Taylor evaluator. It computes an ORDER-degree polynomial y = sum A[k]*x^k by Horner iteration on one shared multiply-add datapath. Coefficients are runtime-programmable and reset to the exp(x) Taylor set. Valid/ready handshakes are on both sides, and the input side can be accepted back-to-back as the output is consumed.

---
 rtl/horner_poly_eval.sv | 163 ++++++++++++++++
 tb/tb_horner_poly_eval.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/horner_poly_eval.sv
// Horner-iteration polynomial evaluator with one shared multiply-add datapath and
// runtime-programmable coefficients. Define SATURATE_EN for clamping arithmetic and o_sat.
module horner_poly_eval #(
    parameter int WIDTHIN  = 16,
    parameter int FRACIN   = 14,
    parameter int WIDTHOUT = 32,
    parameter int FRACOUT  = 25,
    parameter int ORDER    = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [WIDTHIN-1:0]  i_x,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [WIDTHOUT-1:0] o_y,
    input  logic                cfg_we,
    input  logic [3:0]          cfg_addr,
    input  logic [WIDTHIN-1:0]  cfg_data,
`ifdef SATURATE_EN
    output logic                o_sat,
`endif
    output logic                o_busy
);

    localparam int WP = WIDTHOUT + WIDTHIN;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                state_q, state_d;
    logic [WIDTHOUT-1:0]   acc_q, acc_d;
    logic [WIDTHIN-1:0]    x_q, x_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [WIDTHOUT-1:0]   y_q, y_d;
    logic                  accept;
    logic                  coef_we;
    logic [WIDTHIN-1:0]    coef [16];
    logic [WP-1:0]         prod_w;
    logic [WIDTHOUT-1:0]   mulq_w;
    logic [WIDTHOUT-1:0]   step_acc;

    function automatic logic [WIDTHOUT-1:0] align(input logic [WIDTHIN-1:0] c);
        return WIDTHOUT'(c) << (FRACOUT - FRACIN);
    endfunction

    // Power-on coefficients are the exp(x) Taylor series in Q2.14.
    function automatic logic [WIDTHIN-1:0] reset_coef(input int k);
        case (k)
            0:       return WIDTHIN'(16'h4000);
            1:       return WIDTHIN'(16'h4000);
            2:       return WIDTHIN'(16'h2000);
            3:       return WIDTHIN'(16'h0AAA);
            4:       return WIDTHIN'(16'h02AA);
            5:       return WIDTHIN'(16'h0088);
            default: return '0;
        endcase
    endfunction

    assign coef_we = cfg_we && (state_q != CALC) && (cfg_addr <= 4'(ORDER));

    for (genvar gi = 0; gi < 16; gi++) begin : g_coef
        if (gi <= ORDER) begin : g_reg
            logic [WIDTHIN-1:0] coef_q;
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    coef_q <= reset_coef(gi);
                end else if (coef_we && (cfg_addr == 4'(gi))) begin
                    coef_q <= cfg_data;
                end
            end
            assign coef[gi] = coef_q;
        end else begin : g_zero
            assign coef[gi] = '0;
        end
    end

    assign prod_w = WP'(acc_q) * WP'(x_q);
    assign mulq_w = WIDTHOUT'(prod_w >> FRACIN);

`ifdef SATURATE_EN
    logic                sat_q, sat_d;
    logic [WIDTHOUT:0]   sum_w;
    logic                step_sat;

    assign sum_w    = {1'b0, mulq_w} + {1'b0, align(coef[cnt_q])};
    // Sticky: once any step overflows, every later step of this operand stays clamped.
    assign step_sat = sat_q || ((prod_w >> (FRACIN + WIDTHOUT)) != '0) || sum_w[WIDTHOUT];
    assign step_acc = step_sat ? '1 : sum_w[WIDTHOUT-1:0];
    assign o_sat    = sat_q;
`else
    assign step_acc = mulq_w + align(coef[cnt_q]);
`endif

    assign o_ready = (state_q == IDLE) || ((state_q == DONE) && i_ready);
    assign accept  = o_ready && i_valid;
    assign o_valid = (state_q == DONE);
    assign o_busy  = (state_q == CALC);
    assign o_y     = y_q;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        x_d     = x_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
`ifdef SATURATE_EN
        sat_d   = sat_q;
`endif
        case (state_q)
            CALC: begin
                acc_d = step_acc;
                cnt_d = cnt_q - 4'd1;
`ifdef SATURATE_EN
                sat_d = step_sat;
`endif
                if (cnt_q == 4'd0) begin
                    y_d     = step_acc;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (i_ready) begin
                    state_d = IDLE;
                end
            end
            default: ;
        endcase
        // A new operand latches the pre-write top coefficient (registers read before the edge).
        if (accept) begin
            x_d     = i_x;
            acc_d   = align(coef[ORDER]);
            cnt_d   = 4'(ORDER - 1);
            state_d = CALC;
`ifdef SATURATE_EN
            sat_d   = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            x_q     <= '0;
            cnt_q   <= '0;
            y_q     <= '0;
`ifdef SATURATE_EN
            sat_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            x_q     <= x_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
`ifdef SATURATE_EN
            sat_q   <= sat_d;
`endif
        end
    end

endmodule

// File: tb/tb_horner_poly_eval.sv
// Directed testbench for horner_poly_eval: latency, results, backpressure, cfg gating,
// asynchronous reset abort and the SATURATE_EN overflow case.
module tb_horner_poly_eval;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_valid;
    logic        o_ready;
    logic [15:0] i_x;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_y;
    logic        cfg_we;
    logic [3:0]  cfg_addr;
    logic [15:0] cfg_data;
    logic        o_busy;
`ifdef SATURATE_EN
    logic        o_sat;
`endif

    int passed = 0;
    int total  = 0;

    horner_poly_eval dut (
        .clk      (clk),
        .reset    (reset),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_x      (i_x),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_y      (o_y),
        .cfg_we   (cfg_we),
        .cfg_addr (cfg_addr),
        .cfg_data (cfg_data),
`ifdef SATURATE_EN
        .o_sat    (o_sat),
`endif
        .o_busy   (o_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Cycles from the current point until o_valid; a budget of 40 bounds the wait.
    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!o_valid && cyc < 40) begin
            tick();
            cyc++;
        end
    endtask

    task automatic cfg_write(input logic [3:0] addr, input logic [15:0] data);
        cfg_we = 1'b1; cfg_addr = addr; cfg_data = data;
        tick();
        cfg_we = 1'b0;
    endtask

    // Accept x from IDLE, check 5-cycle latency and the result, then consume it.
    task automatic run_op(input string tag, input logic [15:0] x, input logic [31:0] exp_y,
                          input logic exp_sat);
        int cyc;
        chk({tag, "_ready"}, 32'(o_ready), 32'd1);
        i_x = x; i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        i_x = 16'hDEAD;
        chk({tag, "_busy"}, 32'(o_busy), 32'd1);
        wait_valid(cyc);
        chk({tag, "_lat"}, 32'(cyc), 32'd5);
        chk({tag, "_y"}, o_y, exp_y);
`ifdef SATURATE_EN
        chk({tag, "_sat"}, 32'(o_sat), 32'(exp_sat));
`else
        if (exp_sat) $display("note: %s expects clamp only with saturation enabled", tag);
`endif
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        chk({tag, "_vdrop"}, 32'(o_valid), 32'd0);
        $display("op %s: x=%h y=%h latency=%0d", tag, x, o_y, cyc);
    endtask

    function automatic logic [31:0] wrap_model(input logic [15:0] c, input logic [15:0] x);
        logic [31:0] acc;
        logic [63:0] p;
        acc = {16'h0, c} << 11;
        for (int k = 4; k >= 0; k--) begin
            p   = 64'(acc) * 64'(x);
            acc = 32'(p >> 14) + ({16'h0, c} << 11);
        end
        return acc;
    endfunction

    initial begin
        int          cyc;
        logic [31:0] held_y;
        logic [31:0] sat_exp;

        reset = 1'b1; i_valid = 1'b0; i_ready = 1'b0; i_x = '0;
        cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_y",     o_y,          32'h0);
        chk("rst_busy",  32'(o_busy),  32'd0);
        chk("rst_ready", 32'(o_ready), 32'd1);

        run_op("x0",    16'h0000, 32'h0200_0000, 1'b0);
        run_op("x1",    16'h4000, 32'h056E_E000, 1'b0);

        // Backpressure with x=0.5 (exp(0.5) ~ 1.6487), then back-to-back accept in DONE.
        i_x = 16'h2000; i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        wait_valid(cyc);
        chk("bp_lat", 32'(cyc), 32'd5);
        chk("bp_y",   o_y,      32'h034C_2100);
        held_y = 32'h034C_2100;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_hold_valid", 32'(o_valid), 32'd1);
            chk("bp_hold_y",     o_y,          held_y);
            chk("bp_hold_ready", 32'(o_ready), 32'd0);
        end
        $display("backpressure: held y=%h for 10 cycles", o_y);
        i_ready = 1'b1; i_valid = 1'b1; i_x = 16'h4000;
        #1;
        chk("b2b_ready", 32'(o_ready), 32'd1);
        tick();
        i_ready = 1'b0; i_valid = 1'b0;
        chk("b2b_vdrop", 32'(o_valid), 32'd0);
        chk("b2b_busy",  32'(o_busy),  32'd1);
        wait_valid(cyc);
        chk("b2b_lat", 32'(cyc), 32'd5);
        chk("b2b_y",   o_y,      32'h056E_E000);
        $display("back-to-back: y=%h latency=%0d", o_y, cyc);
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;

        // Reprogram to the constant 0.5 polynomial.
        cfg_write(4'd0, 16'h2000);
        for (int k = 1; k <= 5; k++) cfg_write(4'(k), 16'h0000);
        run_op("const", 16'h7FFF, 32'h0100_0000, 1'b0);

        // A write issued mid-CALC must be dropped.
        i_x = 16'h7FFF; i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        cfg_write(4'd0, 16'h1234);
        wait_valid(cyc);
        chk("calcwr_y", o_y, 32'h0100_0000);
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        run_op("calcwr_next", 16'h0000, 32'h0100_0000, 1'b0);

        // Reset pulsed mid-CALC aborts and restores the default coefficients.
        i_x = 16'h4000; i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        tick();
        tick();
        chk("abort_pre_busy", 32'(o_busy), 32'd1);
        reset = 1'b1;
        #1;
        chk("abort_busy",  32'(o_busy),  32'd0);
        chk("abort_valid", 32'(o_valid), 32'd0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("abort_novalid", 32'(o_valid), 32'd0);
        end
        chk("abort_ready", 32'(o_ready), 32'd1);
        chk("abort_y",     o_y,          32'h0);
        $display("abort: reset mid-CALC, o_valid stayed low");
        run_op("restored", 16'h4000, 32'h056E_E000, 1'b0);

        // All-ones coefficients and operand: clamps with saturation, wraps otherwise.
        for (int k = 0; k <= 5; k++) cfg_write(4'(k), 16'hFFFF);
`ifdef SATURATE_EN
        sat_exp = 32'hFFFF_FFFF;
        run_op("ovf", 16'hFFFF, sat_exp, 1'b1);
`else
        sat_exp = wrap_model(16'hFFFF, 16'hFFFF);
        run_op("ovf", 16'hFFFF, sat_exp, 1'b0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
